// File: rtl/rf_fill_verify.sv
// Register-file fill sequencer: writes FIRST_REG..LAST_REG with base + k*stride and,
// in verify mode, reads every register back through read port 1 and counts mismatches.
module rf_fill_verify #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIRST_REG  = 1,
    parameter int LAST_REG   = 31
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  Start,
    input  logic                  Verify_Mode,
    input  logic [DATA_WIDTH-1:0] Fill_Base,
    input  logic [DATA_WIDTH-1:0] Fill_Stride,
    output logic [ADDR_WIDTH-1:0] RF_Write_Address,
    output logic [DATA_WIDTH-1:0] RF_Data_Address_Input,
    output logic                  RF_Write_Enable_Flag,
    output logic [ADDR_WIDTH-1:0] RF_Read_Address1,
    input  logic [DATA_WIDTH-1:0] RF_Data1,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [ADDR_WIDTH-1:0] Error_Address,
    output logic [ADDR_WIDTH-1:0] Error_Count
);

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(FIRST_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LAST_REG);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   ptr_r;
    logic [DATA_WIDTH-1:0]   expected_r;
    logic [DATA_WIDTH-1:0]   base_r;
    logic [DATA_WIDTH-1:0]   stride_r;
    logic                    verify_r;

    logic [ADDR_WIDTH-1:0]   ptr_next_s;
    logic [DATA_WIDTH-1:0]   expected_next_s;
    logic                    last_s;
    logic                    mismatch_s;

    // Pointer/value advance, end-of-sweep detect, compare and read-address decode.
    always_comb begin
        ptr_next_s      = ptr_r + ADDR_ONE;
        expected_next_s = expected_r + stride_r;
        last_s          = (ptr_r == LAST_ADDR);
        mismatch_s      = (RF_Data1 != expected_r);
        if (state_r == VERIFY) begin
            RF_Read_Address1 = ptr_r;
        end else begin
            RF_Read_Address1 = ADDR_ZERO;
        end
    end

    // Sequencer FSM with registered write port and status outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r               <= IDLE;
            ptr_r                 <= ADDR_ZERO;
            expected_r            <= DATA_ZERO;
            base_r                <= DATA_ZERO;
            stride_r              <= DATA_ZERO;
            verify_r              <= 1'b0;
            RF_Write_Address      <= ADDR_ZERO;
            RF_Data_Address_Input <= DATA_ZERO;
            RF_Write_Enable_Flag  <= 1'b0;
            Busy                  <= 1'b0;
            Done                  <= 1'b0;
            Error                 <= 1'b0;
            Error_Address         <= ADDR_ZERO;
            Error_Count           <= ADDR_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        verify_r              <= Verify_Mode;
                        base_r                <= Fill_Base;
                        stride_r              <= Fill_Stride;
                        ptr_r                 <= FIRST_ADDR;
                        expected_r            <= Fill_Base;
                        Error                 <= 1'b0;
                        Error_Address         <= ADDR_ZERO;
                        Error_Count           <= ADDR_ZERO;
                        Busy                  <= 1'b1;
                        // First write is presented in the very next cycle.
                        RF_Write_Enable_Flag  <= 1'b1;
                        RF_Write_Address      <= FIRST_ADDR;
                        RF_Data_Address_Input <= Fill_Base;
                        state_r               <= WRITE;
                    end else begin
                        Busy                  <= 1'b0;
                        RF_Write_Enable_Flag  <= 1'b0;
                        RF_Write_Address      <= ADDR_ZERO;
                        RF_Data_Address_Input <= DATA_ZERO;
                    end
                end
                WRITE: begin
                    if (last_s) begin
                        ptr_r                 <= FIRST_ADDR;
                        expected_r            <= base_r;
                        RF_Write_Enable_Flag  <= 1'b0;
                        RF_Write_Address      <= ADDR_ZERO;
                        RF_Data_Address_Input <= DATA_ZERO;
                        if (verify_r) begin
                            state_r <= VERIFY;
                        end else begin
                            Done    <= 1'b1;
                            state_r <= DONE;
                        end
                    end else begin
                        ptr_r                 <= ptr_next_s;
                        expected_r            <= expected_next_s;
                        RF_Write_Enable_Flag  <= 1'b1;
                        RF_Write_Address      <= ptr_next_s;
                        RF_Data_Address_Input <= expected_next_s;
                    end
                end
                VERIFY: begin
                    if (mismatch_s) begin
                        Error       <= 1'b1;
                        Error_Count <= Error_Count + ADDR_ONE;
                        // Only the first failing address is kept.
                        if (!Error) begin
                            Error_Address <= ptr_r;
                        end
                    end
                    if (last_s) begin
                        ptr_r      <= FIRST_ADDR;
                        expected_r <= base_r;
                        Done       <= 1'b1;
                        state_r    <= DONE;
                    end else begin
                        ptr_r      <= ptr_next_s;
                        expected_r <= expected_next_s;
                    end
                end
                DONE: begin
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    Done                 <= 1'b0;
                    Busy                 <= 1'b0;
                    RF_Write_Enable_Flag <= 1'b0;
                    state_r              <= IDLE;
                end
            endcase
        end
    end

endmodule
